// File: rtl/imem_loader_if.sv
// Byte-stream, control and memory-write signals of the instruction-memory loader.
// The master side drives the stream and start; the slave side is the loader.
interface imem_loader_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH) + 1
);
  logic             start;
  logic [AW-1:0]    word_count;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             mem_we;
  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_wdata;
  logic             busy;
  logic             done;
  logic             error;
  logic             cpu_rst_n;

  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_address, mem_wdata, busy, done, error, cpu_rst_n
  );

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, mem_we, mem_address, mem_wdata, busy, done, error, cpu_rst_n
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words, writes them sequentially
// into instruction memory, and holds the CPU in reset until the load completes.
module imem_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  lif
);
  localparam int AW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t         state;
  logic [1:0]     lane;
  logic [IW-1:0]  idx;
  logic [AW-1:0]  count;
  logic [2:0][7:0] asm_lo;

  function automatic logic count_ok(input logic [AW-1:0] wc);
    return (wc != '0) && (wc <= AW'(DEPTH));
  endfunction

  // Lower three bytes of the word in flight; the fourth goes straight to mem_wdata.
  always_ff @(posedge clk) begin
    if (state == RECV && lif.byte_valid && lane != 2'd3)
      asm_lo[lane] <= lif.byte_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      lane            <= '0;
      idx             <= '0;
      count           <= '0;
      lif.byte_ready  <= 1'b0;
      lif.mem_we      <= 1'b0;
      lif.mem_address <= '0;
      lif.mem_wdata   <= '0;
      lif.busy        <= 1'b0;
      lif.done        <= 1'b0;
      lif.error       <= 1'b0;
      lif.cpu_rst_n   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (lif.start) begin
            lif.done      <= 1'b0;
            lif.cpu_rst_n <= 1'b0;
            if (count_ok(lif.word_count)) begin
              count          <= lif.word_count;
              idx            <= '0;
              lane           <= '0;
              lif.error      <= 1'b0;
              lif.byte_ready <= 1'b1;
              lif.busy       <= 1'b1;
              state          <= RECV;
            end else begin
              lif.error <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        RECV: begin
          if (lif.byte_valid) begin
            if (lane == 2'd3) begin
              lane            <= '0;
              lif.byte_ready  <= 1'b0;
              lif.mem_we      <= 1'b1;
              lif.mem_address <= WIDTH'({idx, 2'b00});
              lif.mem_wdata   <= WIDTH'({lif.byte_data, asm_lo[2], asm_lo[1], asm_lo[0]});
              state           <= WRITE;
            end else begin
              lane <= lane + 2'd1;
            end
          end
        end
        WRITE: begin
          lif.mem_we <= 1'b0;
          // A valid count never exceeds DEPTH, so idx stops at DEPTH-1.
          if (({1'b0, idx} + AW'(1)) == count) begin
            lif.busy      <= 1'b0;
            lif.done      <= 1'b1;
            lif.cpu_rst_n <= 1'b1;
            state         <= DONE;
          end else begin
            idx            <= idx + 1'b1;
            lif.byte_ready <= 1'b1;
            state          <= RECV;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a byte-queue reference model and per-cycle invariants.
module tb_imem_loader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2048;
  localparam int AW    = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) lif ();
  imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .lif(lif));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes actually accepted, and writes observed on the memory port.
  logic [7:0]  acc_q[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          exp_n = 0;
  bit          prev_we = 1'b0;
  int          k;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("inv_cpurst", 32'(lif.cpu_rst_n), 32'(lif.done));
        if (lif.busy) check("inv_ready", 32'(lif.byte_ready), 32'(!lif.mem_we));
        else          check("inv_idle", 32'({lif.byte_ready, lif.mem_we}), 32'd0);
        if (lif.mem_we) begin
          k = obs_addr.size();
          check("we_bytes", 32'(acc_q.size()), 32'(4 * (k + 1)));
          if (acc_q.size() >= 4 * (k + 1))
            check("we_data", lif.mem_wdata,
                  {acc_q[4*k+3], acc_q[4*k+2], acc_q[4*k+1], acc_q[4*k]});
          check("we_addr", lif.mem_address, 32'(k * 4));
          check("we_pulse", 32'(prev_we), 32'd0);
          obs_addr.push_back(lif.mem_address);
          obs_data.push_back(lif.mem_wdata);
        end
        if (prev_we && obs_addr.size() == exp_n) begin
          check("done_next", 32'(lif.done), 32'd1);
          check("busy_off", 32'(lif.busy), 32'd0);
        end
        if (lif.byte_valid && lif.byte_ready) acc_q.push_back(lif.byte_data);
        prev_we = lif.mem_we;
      end else begin
        prev_we = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model(input int n);
    acc_q.delete();
    obs_addr.delete();
    obs_data.delete();
    exp_n = n;
  endtask

  task automatic do_start(input int n, input bit ovl, input logic [7:0] b0, input bit ok);
    lif.start      = 1'b1;
    lif.word_count = AW'(n);
    if (ovl) begin
      lif.byte_valid = 1'b1;
      lif.byte_data  = b0;
    end
    tick();
    lif.start = 1'b0;
    check("start_ready", 32'(lif.byte_ready), 32'(ok));
    check("start_busy", 32'(lif.busy), 32'(ok));
    check("start_err", 32'(lif.error), 32'(!ok));
    check("start_done", 32'(lif.done), 32'd0);
    check("start_cpurst", 32'(lif.cpu_rst_n), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    lif.byte_valid = 1'b1;
    lif.byte_data  = b;
    while (!lif.byte_ready && n < 64) begin
      tick();
      n++;
    end
    if (!lif.byte_ready) check("byte_tmo", 32'd0, 32'd1);
    tick();
    lif.byte_valid = 1'b0;
    lif.byte_data  = 8'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!lif.done && n < 100) begin
      tick();
      n++;
    end
    check("done", 32'(lif.done), 32'd1);
    check("done_cpurst", 32'(lif.cpu_rst_n), 32'd1);
    check("done_busy", 32'(lif.busy), 32'd0);
    check("done_err", 32'(lif.error), 32'd0);
  endtask

  task automatic send_words(input logic [31:0] w[$], input int first, input int gap, input bit rnd);
    for (int i = 0; i < w.size(); i++)
      for (int j = 0; j < 4; j++) begin
        if (i * 4 + j >= first) begin
          send_byte(w[i][8*j +: 8]);
          repeat (rnd ? $urandom_range(3, 0) : gap) tick();
        end
      end
  endtask

  task automatic compare_writes(input logic [31:0] w[$]);
    check("wr_count", 32'(obs_addr.size()), 32'(w.size()));
    for (int i = 0; i < w.size() && i < obs_addr.size(); i++) begin
      check("wr_addr", obs_addr[i], 32'(i * 4));
      check("wr_data", obs_data[i], w[i]);
    end
  endtask

  task automatic load(input logic [31:0] w[$], input int gap, input bit rnd, input bit ovl);
    clear_model(w.size());
    do_start(w.size(), ovl, w[0][7:0], 1'b1);
    send_words(w, 0, gap, rnd);
    wait_done();
    compare_writes(w);
  endtask

  logic [31:0] words[$];

  initial begin
    lif.start      = 1'b0;
    lif.word_count = '0;
    lif.byte_valid = 1'b0;
    lif.byte_data  = '0;

    repeat (3) tick();
    check("rst_ready", 32'(lif.byte_ready), 32'd0);
    check("rst_we", 32'(lif.mem_we), 32'd0);
    check("rst_addr", lif.mem_address, 32'd0);
    check("rst_wdata", lif.mem_wdata, 32'd0);
    check("rst_busy", 32'(lif.busy), 32'd0);
    check("rst_done", 32'(lif.done), 32'd0);
    check("rst_err", 32'(lif.error), 32'd0);
    check("rst_cpurst", 32'(lif.cpu_rst_n), 32'd0);
    rst_n = 1'b1;
    tick();

    words = '{32'h0000_0013, 32'h5634_12B7};
    load(words, 0, 1'b0, 1'b0);
    load(words, 3, 1'b0, 1'b0);

    clear_model(0);
    do_start(0, 1'b0, 8'h00, 1'b0);
    repeat (2) tick();
    do_start(DEPTH + 1, 1'b0, 8'h00, 1'b0);
    repeat (4) tick();
    check("rej_busy", 32'(lif.busy), 32'd0);
    check("rej_cpurst", 32'(lif.cpu_rst_n), 32'd0);
    check("rej_nowrite", 32'(obs_addr.size()), 32'd0);

    for (int t = 0; t < 6; t++) begin
      words.delete();
      for (int i = 0; i < $urandom_range(8, 1); i++) words.push_back($urandom);
      load(words, 0, 1'b1, t[0]);
    end

    words = '{$urandom, $urandom};
    clear_model(2);
    do_start(2, 1'b0, 8'h00, 1'b1);
    send_byte(words[0][7:0]);
    lif.start      = 1'b1;
    lif.word_count = '0;
    tick();
    lif.start = 1'b0;
    check("busy_start_err", 32'(lif.error), 32'd0);
    check("busy_start_busy", 32'(lif.busy), 32'd1);
    send_words(words, 1, 0, 1'b1);
    wait_done();
    compare_writes(words);
    words = '{$urandom};
    load(words, 0, 1'b0, 1'b0);

    words = '{$urandom, $urandom};
    clear_model(2);
    do_start(2, 1'b0, 8'h00, 1'b1);
    send_byte(words[0][7:0]);
    send_byte(words[0][15:8]);
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(lif.byte_ready), 32'd0);
    check("arst_busy", 32'(lif.busy), 32'd0);
    check("arst_we", 32'(lif.mem_we), 32'd0);
    check("arst_cpurst", 32'(lif.cpu_rst_n), 32'd0);
    check("arst_done", 32'(lif.done), 32'd0);
    check("arst_wdata", lif.mem_wdata, 32'd0);
    repeat (3) tick();
    check("arst_nowrite", 32'(obs_addr.size()), 32'd0);
    rst_n = 1'b1;
    tick();
    words = '{$urandom};
    load(words, 0, 1'b0, 1'b1);

    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back(32'(i));
    load(words, 0, 1'b0, 1'b0);
    if (obs_addr.size() == DEPTH) check("full_last_addr", obs_addr[DEPTH-1], 32'h0000_1FFC);
    else                          check("full_size", 32'(obs_addr.size()), 32'(DEPTH));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the asynchronous instruction ROM. It accepts a little-endian byte stream, typically from a UART receiver or a testbench, and packs each four bytes into a 32-bit word. Each word is written sequentially into a writable instruction memory through a single write port. The loader holds the CPU in reset until the requested number of words has been written, then releases it, so programs can be loaded at run time instead of only by compile-time include.

## Interface
- WIDTH, 32, data and address width; must be 32.
- DEPTH, 2048, number of words in the target instruction memory.
- AW, $clog2(DEPTH)+1, width of word_count; derived, not overridden.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE.
- word_count  input  AW  number of words to load; sampled when start is accepted.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte, least-significant byte of each word first.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  write strobe to instruction memory; one cycle per word.
- mem_address  output  WIDTH  byte address, word-aligned ([1:0]=0); the memory indexes it with address[WIDTH-1:2].
- mem_wdata  output  WIDTH  assembled word.
- busy  output  1  a load is in progress.
- done  output  1  the last load completed successfully.
- error  output  1  the last start was rejected.
- cpu_rst_n  output  1  active-low reset to the CPU core.

## Operation
- The block has four states: IDLE, RECV, WRITE and DONE.
- **IDLE:**
  - The block enters IDLE after reset.
  - On start, it checks word_count. If 1 <= word_count <= DEPTH, it clears the word index, byte lane and error, then goes to RECV. Otherwise it sets error and stays in IDLE.
- **RECV:**
  - byte_ready=1.
  - Each handshake (byte_valid && byte_ready) stores byte_data into lane 0..3 of the assembly register, at bits [8*lane+7:8*lane], then increments lane.
  - Accepting lane 3 moves the state to WRITE and resets lane to 0.
  - Cycles without byte_valid hold all state.
- **WRITE:**
  - byte_ready=0 and mem_we=1 for exactly one cycle.
  - mem_address = word index × 4; mem_wdata = the assembled word.
  - If word index+1 == the latched count, go to DONE. Otherwise increment the word index and return to RECV.
- **DONE:**
  - done=1 and cpu_rst_n=1; the loader then stays idle.
  - On start, the word_count check is repeated:
    - If the count is valid, clear done, drive cpu_rst_n=0 and go to RECV.
    - If the count is invalid, set error, clear done and drive cpu_rst_n=0. The next state is IDLE.
- busy=1 in RECV and WRITE. start is ignored while busy.
- cpu_rst_n=0 in every state except DONE.
- The word index saturates logically at DEPTH-1. An address at or above DEPTH×4 is never driven, because an out-of-range count is rejected at start.
- byte_data is ignored while byte_ready=0. A byte presented during WRITE stays pending until RECV.
- Bytes arriving after DONE are not accepted, because byte_ready=0.

## Timing
- Reset values:
  - byte_ready=0, mem_we=0, mem_address=0, mem_wdata=0.
  - busy=0, done=0, error=0, cpu_rst_n=0.
  - Internal counters are 0 and the state is IDLE.
- All outputs are registered or decoded directly from the state; there is no combinational path from byte_valid to any output.
- start accepted in cycle T → byte_ready=1 in T+1.
- Fourth byte of a word accepted in cycle N → mem_we=1 in N+1 → byte_ready=1 again in N+2.
- Best-case throughput is 5 cycles per word.
- The final write occurs in cycle W → in W+1, done=1, cpu_rst_n=1 and busy=0.
- Asserting rst_n low mid-load aborts immediately and asynchronously to the reset values. A partial word is discarded and no write is issued.
- If start and byte_valid are both high in the same IDLE cycle, only start takes effect. The byte is first accepted in T+1.

## Test plan
- **Two-word load.** Stimulus: start with word_count=2, then bytes 13 00 00 00 B7 12 34 56, back to back. Required response: writes addr 0x0 data 0x00000013 and addr 0x4 data 0x563412B7; done=1 and cpu_rst_n=1 one cycle after the second mem_we; exactly 2 mem_we pulses.
- **Backpressure gaps.** Stimulus: same stream with byte_valid low for 3 cycles between every byte. Required response: identical writes and data; mem_we never asserted early; byte_ready=0 only in WRITE.
- **Rejected counts.** Stimulus: start with word_count=0, then with word_count=DEPTH+1. Required response: error=1 both times, busy stays 0, no mem_we, cpu_rst_n stays 0.
- **Full-depth load.** Stimulus: word_count=DEPTH with incrementing data. Required response: DEPTH writes, the last at addr (DEPTH-1)×4 (0x1FFC for 2048), then done=1.
- **Reset mid-word.** Stimulus: assert rst_n=0 after 2 bytes of word 1. Required response: all outputs return to reset values immediately and no write is issued. After release, a fresh start with word_count=1 loads cleanly at addr 0x0.
- **Start ignored while busy; reload from DONE.** Stimulus: pulse start while busy, then start again from DONE with word_count=1. Required response: the pulse while busy has no effect. The restart from DONE drops cpu_rst_n to 0 the next cycle and clears done, then done reasserts after the single write.
